apu_test_probe: RTL and testbench

// - Parametrised successor of the 2A03G APU test-mode readout: one register-mapped debug port.
// - Selects one of NUM_CH channel outputs and samples it every DIV+1 clocks into a DEPTH-entry FIFO.
// - The CPU drains the FIFO over DB; the block keeps the LOCK test-mode bit.
// - Sits beside the APU channels on the APU side of the CPU data bus DB.

---
 rtl/apu_test_probe_if.sv | 15 +
 rtl/apu_test_probe.sv | 204 ++++++++++++++++++++
 tb/tb_apu_test_probe.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/apu_test_probe_if.sv
// apu_test_probe_if: CPU-side strobes and channel sample bus of the APU test probe.
// The data bus DB itself stays a plain inout port on the probe.
interface apu_test_probe_if #(
   parameter int unsigned NUM_CH = 5,
   parameter int unsigned CH_W   = 7
);
   logic                     W_CTRL;
   logic                     W_DIV;
   logic                     n_R_DATA;
   logic                     n_R_STAT;
   logic [NUM_CH*CH_W-1:0]   CH_in;

   modport master (output W_CTRL, W_DIV, n_R_DATA, n_R_STAT, CH_in);
   modport slave  (input  W_CTRL, W_DIV, n_R_DATA, n_R_STAT, CH_in);
endinterface

// File: rtl/apu_test_probe.sv
// apu_test_probe: register-mapped APU debug port. Samples one selected channel
// every DIV+1 clocks into a DEPTH-entry FIFO that the CPU drains over DB.
// Optional feature: define APU_TEST_TRIGGER_EN to arm into WAIT_TRIG, which
// starts capture on the first change of the selected channel.
module apu_test_probe #(
   parameter int unsigned NUM_CH = 5,
   parameter int unsigned CH_W   = 7,
   parameter int unsigned DEPTH  = 8
) (
   input  logic            ACLK1,
   input  logic            RES,
   inout  wire  [7:0]      DB,
   apu_test_probe_if.slave bus,
   output logic            LOCK
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DONE    = 2'd2
`ifdef APU_TEST_TRIGGER_EN
      , S_WAIT_TRIG = 2'd3
`endif
   } state_t;

`ifdef APU_TEST_TRIGGER_EN
   localparam state_t ARM_STATE = S_WAIT_TRIG;
`else
   localparam state_t ARM_STATE = S_CAPTURE;
`endif

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [7:0]              r_div_cnt;
   logic [7:0]              w_div_cnt_nxt;
   logic [7:0]              r_div;
   logic [2:0]              r_sel;
   logic                    r_lock;
   logic                    r_ndata_q;
   logic [PTR_W-1:0]        r_wptr;
   logic [PTR_W-1:0]        r_rptr;
   logic [CNT_W-1:0]        r_count;
   logic [CH_W-1:0]         r_mem [DEPTH];

   logic [NUM_CH*CH_W-1:0]  w_ch_bus;
   logic [CH_W-1:0]         w_sample;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_flush;
   logic                    w_clr;
   logic                    w_arm;
   logic                    w_full;
   logic                    w_capturing;
   logic                    w_fill_done;
   logic                    w_db_oe;
   logic [7:0]              w_db_out;
   logic [7:0]              w_stat;
   logic                    w_unused_db;

   // Channel k of the flat bus; selectors past NUM_CH yield zero.
   function automatic logic [CH_W-1:0] f_pick(input logic [NUM_CH*CH_W-1:0] ch,
                                              input logic [2:0] sel);
      logic [CH_W-1:0] v;
      v = '0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         if (int'(sel) == k) v = ch[k*CH_W +: CH_W];
      end
      return v;
   endfunction

   assign w_ch_bus    = bus.CH_in;
   assign w_sample    = f_pick(w_ch_bus, r_sel);
   assign w_clr       = bus.W_CTRL & DB[5];
   assign w_arm       = bus.W_CTRL & DB[6] & ~DB[5];
   assign w_full      = (r_count == CNT_W'(DEPTH));
   assign w_pop       = bus.n_R_DATA & ~r_ndata_q & (r_count != '0);
   assign w_unused_db = &{DB[4:3]};
   assign LOCK        = r_lock;

`ifdef APU_TEST_TRIGGER_EN
   logic [CH_W-1:0] r_prev;

   // Previous sample of the selected channel; reloaded from the newly written SEL on ARM.
   always_ff @(posedge ACLK1 or posedge RES) begin
      if (RES)        r_prev <= '0;
      else if (w_arm) r_prev <= f_pick(w_ch_bus, DB[2:0]);
      else            r_prev <= w_sample;
   end

   assign w_capturing = (r_state == S_CAPTURE) || (r_state == S_WAIT_TRIG);
`else
   assign w_capturing = (r_state == S_CAPTURE);
`endif

   // Next state, divider countdown and push/flush decisions.
   always_comb begin
      w_state_nxt   = r_state;
      w_div_cnt_nxt = r_div_cnt;
      w_push        = 1'b0;
      w_flush       = 1'b0;
      w_fill_done   = 1'b0;
      case (r_state)
         S_IDLE: ;
         S_CAPTURE: begin
            if (r_div_cnt == 8'd0) begin
               w_push        = ~w_full;
               w_div_cnt_nxt = r_div;
            end else begin
               w_div_cnt_nxt = r_div_cnt - 8'd1;
            end
            if (w_full) w_state_nxt = S_DONE;
         end
`ifdef APU_TEST_TRIGGER_EN
         S_WAIT_TRIG: begin
            if (w_sample != r_prev) begin
               w_push        = ~w_full;
               w_div_cnt_nxt = r_div;
               w_state_nxt   = S_CAPTURE;
            end
         end
`endif
         S_DONE: begin
            // Draining the last entry of a finished capture returns to IDLE.
            if (w_pop && (r_count == CNT_W'(1))) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_push && !w_pop && (r_count == CNT_W'(DEPTH - 1))) w_state_nxt = S_DONE;

      if (w_clr) begin
         w_push      = 1'b0;
         w_flush     = 1'b1;
         w_state_nxt = S_IDLE;
      end else if (w_arm) begin
         w_div_cnt_nxt = 8'd0;
         w_fill_done   = (w_state_nxt == S_DONE) && (w_full || w_push);
         if (!w_fill_done) w_state_nxt = ARM_STATE;
      end
   end

   // FSM state and divider counter.
   always_ff @(posedge ACLK1 or posedge RES) begin
      if (RES) begin
         r_state   <= S_IDLE;
         r_div_cnt <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_div_cnt <= w_div_cnt_nxt;
      end
   end

   // Control/divider registers and the DATA strobe history for pop edge detection.
   always_ff @(posedge ACLK1 or posedge RES) begin
      if (RES) begin
         r_lock    <= 1'b0;
         r_sel     <= 3'd0;
         r_div     <= 8'd0;
         r_ndata_q <= 1'b1;
      end else begin
         if (bus.W_CTRL) begin
            r_lock <= DB[7];
            r_sel  <= DB[2:0];
         end
         if (bus.W_DIV) r_div <= DB;
         r_ndata_q <= bus.n_R_DATA;
      end
   end

   // FIFO pointers and occupancy; flush wins over push and pop.
   always_ff @(posedge ACLK1 or posedge RES) begin
      if (RES) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (w_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      end
   end

   // FIFO storage; contents are meaningless outside count.
   always_ff @(posedge ACLK1) begin
      if (w_push) r_mem[r_wptr] <= w_sample;
   end

   // Combinational read-back onto DB; DATA has priority over STAT.
   always_comb begin
      w_stat   = {w_full, w_capturing, (r_state == S_DONE), 5'(r_count)};
      w_db_oe  = ~bus.n_R_DATA | ~bus.n_R_STAT;
      w_db_out = w_stat;
      if (!bus.n_R_DATA) w_db_out = (r_count != '0) ? 8'(r_mem[r_rptr]) : 8'h00;
   end

   assign DB = w_db_oe ? w_db_out : 8'hzz;
endmodule

// File: tb/tb_apu_test_probe.sv
// tb_apu_test_probe: self-checking bench for apu_test_probe (NUM_CH=5, CH_W=7, DEPTH=8).
module tb_apu_test_probe;
   logic       clk = 1'b0;
   logic       rst;
   wire  [7:0] DB;
   logic [7:0] tb_db;
   logic       tb_db_en;
   logic       lock;
   logic [6:0] ramp;
   logic       ramp_en;
   int         n_err = 0;
   int         n_chk = 0;
   logic [7:0] q_exp [$];

   typedef struct {
      logic [7:0] ctrl;
      logic       exp_lock;
      logic [7:0] exp_stat;
      string      name;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   assign DB = tb_db_en ? tb_db : 8'hzz;

   apu_test_probe_if #(.NUM_CH(5), .CH_W(7)) bus ();

   apu_test_probe #(.NUM_CH(5), .CH_W(7), .DEPTH(8)) dut (
      .ACLK1 (clk),
      .RES   (rst),
      .DB    (DB),
      .bus   (bus),
      .LOCK  (lock)
   );

   task automatic drive_ch();
      bus.CH_in = {7'h44, 7'h33, ramp, 7'h02, 7'h01};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (ramp_en) ramp = ramp + 7'd1;
      drive_ch();
   endtask

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h, want %02h", nm, act, exp);
      end
   endtask

   task automatic wr_ctrl(input logic [7:0] v);
      bus.W_CTRL = 1'b1; tb_db = v; tb_db_en = 1'b1;
      tick();
      bus.W_CTRL = 1'b0; tb_db_en = 1'b0;
   endtask

   task automatic wr_div(input logic [7:0] v);
      bus.W_DIV = 1'b1; tb_db = v; tb_db_en = 1'b1;
      tick();
      bus.W_DIV = 1'b0; tb_db_en = 1'b0;
   endtask

   task automatic rd_stat(output logic [7:0] v);
      bus.n_R_STAT = 1'b0; #1;
      v = DB;
      bus.n_R_STAT = 1'b1; #1;
   endtask

   // Leaves n_R_DATA low; the pop happens on the edge after it returns high.
   task automatic peek_data(output logic [7:0] v);
      bus.n_R_DATA = 1'b0; #1;
      v = DB;
   endtask

   task automatic read_pop(output logic [7:0] v);
      peek_data(v);
      tick();
      bus.n_R_DATA = 1'b1;
      tick();
   endtask

   task automatic check_hiz(input string nm);
      tb_db = 8'hA5; tb_db_en = 1'b1; #1;
      check({nm, "_a5"}, DB, 8'hA5);
      tb_db = 8'h5A; #1;
      check({nm, "_5a"}, DB, 8'h5A);
      tb_db_en = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] s;
      logic [7:0] d;
      logic [6:0] r0;
      logic [6:0] t;

      vecs[0] = '{8'h80, 1'b1, 8'h00, "lock_set"};
      vecs[1] = '{8'h00, 1'b0, 8'h00, "lock_clr"};
      vecs[2] = '{8'hC2, 1'b1, 8'h41, "arm_first"};
      vecs[3] = '{8'h42, 1'b0, 8'h42, "rearm_keep"};
      vecs[4] = '{8'h80, 1'b1, 8'h42, "lock_fifo_kept"};
      vecs[5] = '{8'h60, 1'b0, 8'h00, "clr_over_arm"};
      vecs[6] = '{8'h07, 1'b0, 8'h00, "sel_only"};
      vecs[7] = '{8'hA0, 1'b1, 8'h00, "clr_lock"};

      rst = 1'b1; tb_db = 8'h00; tb_db_en = 1'b0;
      bus.W_CTRL = 1'b0; bus.W_DIV = 1'b0;
      bus.n_R_DATA = 1'b1; bus.n_R_STAT = 1'b1;
      ramp = 7'h10; ramp_en = 1'b1;
      drive_ch();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_lock", {7'd0, lock}, 8'h00);
      rd_stat(s);
      check("rst_stat", s, 8'h00);
      check_hiz("rst_hiz");

      // Table: control writes with a long divider so at most one sample per ARM.
      wr_div(8'd200);
      for (int i = 0; i < 8; i++) begin
         wr_ctrl(vecs[i].ctrl);
         tick();
         rd_stat(s);
         check({vecs[i].name, "_stat"}, s, vecs[i].exp_stat);
         check({vecs[i].name, "_lock"}, {7'd0, lock}, {7'd0, vecs[i].exp_lock});
      end

      // Fill: SEL=2, DIV=3, ramp on ch2.
      wr_div(8'd3);
      r0 = ramp;
      for (int i = 0; i < 8; i++) begin
         t = r0 + 7'(1 + 4 * i);
         q_exp.push_back({1'b0, t});
      end
      wr_ctrl(8'h42);
      repeat (28) tick();
      rd_stat(s);
      check("fill_28", s, 8'h47);
      tick();
      rd_stat(s);
      check("fill_29", s, 8'hA8);
      repeat (3) tick();
      rd_stat(s);
      check("fill_hold", s, 8'hA8);

      // Drain: eight samples in order, then an empty read.
      for (int i = 0; i < 8; i++) begin
         read_pop(d);
         check($sformatf("drain_%0d", i), d, q_exp.pop_front());
      end
      read_pop(d);
      check("drain_empty", d, 8'h00);
      rd_stat(s);
      check("drain_stat", s, 8'h00);

      // Concurrency: a pop lands on every push edge, count stays 1, pointers wrap.
      wr_div(8'd1);
      r0 = ramp;
      for (int i = 0; i < 10; i++) begin
         t = r0 + 7'(1 + 2 * i);
         q_exp.push_back({1'b0, t});
      end
      wr_ctrl(8'h42);
      for (int i = 0; i < 10; i++) begin
         tick();
         rd_stat(s);
         check($sformatf("conc_stat_%0d", i), s, 8'h41);
         peek_data(d);
         check($sformatf("conc_data_%0d", i), d, q_exp.pop_front());
         tick();
         bus.n_R_DATA = 1'b1;
      end
      wr_ctrl(8'h20);
      rd_stat(s);
      check("conc_clr", s, 8'h00);

      // Out-of-range SEL samples zero; LOCK held through capture.
      wr_div(8'd0);
      wr_ctrl(8'hC6);
      tick();
      rd_stat(s);
      check("sel6_stat", s, 8'h41);
      peek_data(d);
      check("sel6_data", d, 8'h00);
      bus.n_R_DATA = 1'b1;
      check("sel6_lock", {7'd0, lock}, 8'h01);

      // Reset mid-capture.
      tick();
      rst = 1'b1; #1;
      check("midrst_lock", {7'd0, lock}, 8'h00);
      rd_stat(s);
      check("midrst_stat", s, 8'h00);
      check_hiz("midrst_hiz");
      tick();
      rst = 1'b0;
      tick();
      rd_stat(s);
      check("postrst_stat", s, 8'h00);

`ifdef APU_TEST_TRIGGER_EN
      // Trigger: constant channel holds in WAIT_TRIG, first change is the first entry.
      ramp_en = 1'b0;
      ramp = 7'h11;
      drive_ch();
      wr_ctrl(8'h42);
      repeat (10) tick();
      rd_stat(s);
      check("trig_wait", s, 8'h40);
      ramp = 7'h22;
      drive_ch();
      tick();
      peek_data(d);
      check("trig_first", d, 8'h22);
      bus.n_R_DATA = 1'b1;
      ramp_en = 1'b1;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
